// File: rtl/serdes_align_pkg.sv
// Shared types, defaults and helpers for the F2F serdes lane-alignment block.
package serdes_align_pkg;

  localparam int unsigned DEF_LANES     = 5;
  localparam int unsigned DEF_SER_W     = 8;
  localparam logic [7:0]  DEF_TRAIN_PAT = 8'h0F;
  localparam int unsigned DEF_MATCH_CNT = 16;
  localparam int unsigned DEF_SLIP_WAIT = 4;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SLIP,
    WAIT,
    LOCKED,
    FAIL
  } lane_state_t;

  // Width of a saturating counter that must hold values 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lane_align_fsm.sv
// One lane's bitslip-alignment state machine: compares the received word with
// the training pattern, pulses bitslip until it matches, then locks or fails.
module lane_align_fsm
  import serdes_align_pkg::*;
#(
  parameter int unsigned      SER_W     = DEF_SER_W,
  parameter logic [SER_W-1:0] TRAIN_PAT = SER_W'(DEF_TRAIN_PAT),
  parameter int unsigned      MATCH_CNT = DEF_MATCH_CNT,
  parameter int unsigned      SLIP_WAIT = DEF_SLIP_WAIT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             train_start,
  input  logic [SER_W-1:0] rx_word,
  output logic             bitslip,
  output logic             locked,
  output logic             fail
);

  localparam int unsigned MCW = cnt_w(MATCH_CNT);
  localparam int unsigned SCW = cnt_w(SER_W);
  localparam int unsigned WCW = cnt_w(SLIP_WAIT);

  lane_state_t    state_q, state_d;
  logic [MCW-1:0] match_q, match_d;
  logic [SCW-1:0] slip_q,  slip_d;
  logic [WCW-1:0] wait_q,  wait_d;
  logic           word_match;

  assign word_match = (rx_word == TRAIN_PAT);

  // State, counters and registered state decodes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      match_q <= '0;
      slip_q  <= '0;
      wait_q  <= '0;
      bitslip <= 1'b0;
      locked  <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      slip_q  <= slip_d;
      wait_q  <= wait_d;
      bitslip <= (state_d == SLIP);
      locked  <= (state_d == LOCKED);
      fail    <= (state_d == FAIL);
    end
  end

  // Next-state logic; a restart overrides every other transition.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    slip_d  = slip_q;
    wait_d  = wait_q;
    if (train_start) begin
      state_d = CHECK;
      match_d = '0;
      slip_d  = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        CHECK: begin
          if (word_match) begin
            if (match_q == MCW'(MATCH_CNT - 1)) state_d = LOCKED;
            if (match_q != MCW'(MATCH_CNT))     match_d = match_q + MCW'(1);
          end else begin
            match_d = '0;
            state_d = (slip_q == SCW'(SER_W)) ? FAIL : SLIP;
          end
        end
        SLIP: begin
          state_d = WAIT;
          match_d = '0;
          wait_d  = '0;
          if (slip_q != SCW'(SER_W)) slip_d = slip_q + SCW'(1);
        end
        WAIT: begin
          match_d = '0;
          if (wait_q == WCW'(SLIP_WAIT - 1)) state_d = CHECK;
          else                               wait_d  = wait_q + WCW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/serdes_lane_align.sv
// F2F link alignment: TX word/tristate registers, one alignment FSM per RX lane,
// and the link-up qualified RX data path.
module serdes_lane_align
  import serdes_align_pkg::*;
#(
  parameter int unsigned      LANES     = DEF_LANES,
  parameter int unsigned      SER_W     = DEF_SER_W,
  parameter logic [SER_W-1:0] TRAIN_PAT = SER_W'(DEF_TRAIN_PAT),
  parameter int unsigned      MATCH_CNT = DEF_MATCH_CNT,
  parameter int unsigned      SLIP_WAIT = DEF_SLIP_WAIT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   train_start,
  input  logic                   tx_train,
  input  logic                   tx_en,
  input  logic [LANES*SER_W-1:0] tx_din,
  input  logic [LANES*SER_W-1:0] rx_word,
  output logic [LANES*SER_W-1:0] tx_dout,
  output logic                   tx_tristate,
  output logic [LANES-1:0]       bitslip,
  output logic [LANES-1:0]       lane_locked,
  output logic [LANES-1:0]       lane_fail,
  output logic                   link_up,
  output logic [LANES*SER_W-1:0] rx_dout,
  output logic                   rx_valid
);

  // TX pads and link-level RX qualification.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_dout     <= '0;
      tx_tristate <= 1'b1;
      link_up     <= 1'b0;
      rx_dout     <= '0;
      rx_valid    <= 1'b0;
    end else begin
      tx_dout     <= tx_train ? {LANES{TRAIN_PAT}} : tx_din;
      tx_tristate <= ~tx_en;
      link_up     <= &lane_locked;
      rx_dout     <= rx_word;
      rx_valid    <= link_up;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_align_fsm #(
      .SER_W     (SER_W),
      .TRAIN_PAT (TRAIN_PAT),
      .MATCH_CNT (MATCH_CNT),
      .SLIP_WAIT (SLIP_WAIT)
    ) u_fsm (
      .clk         (clk),
      .reset_n     (reset_n),
      .train_start (train_start),
      .rx_word     (rx_word[i*SER_W +: SER_W]),
      .bitslip     (bitslip[i]),
      .locked      (lane_locked[i]),
      .fail        (lane_fail[i])
    );
  end

endmodule

// File: tb/tb_serdes_lane_align.sv
// Scoreboard bench: a rotating-deserializer channel model feeds the DUT, and
// expected slip/lock/fail timing is computed from the alignment timing rules.
module tb_serdes_lane_align;

  localparam int unsigned      LANES     = 5;
  localparam int unsigned      SER_W     = 8;
  localparam int unsigned      MATCH_CNT = 16;
  localparam int unsigned      SLIP_WAIT = 4;
  localparam int unsigned      W         = LANES * SER_W;
  localparam logic [SER_W-1:0] PAT       = 8'h0F;
  localparam int               SLIP_P    = int'(SLIP_WAIT) + 2;
  localparam int               NEVER     = 1073741823;

  logic           clk = 1'b0;
  logic           reset_n, train_start, tx_train, tx_en;
  logic [W-1:0]   tx_din, rx_word, tx_dout, rx_dout;
  logic           tx_tristate, link_up, rx_valid;
  logic [LANES-1:0] bitslip, lane_locked, lane_fail;

  serdes_lane_align #(
    .LANES(LANES), .SER_W(SER_W), .TRAIN_PAT(PAT),
    .MATCH_CNT(MATCH_CNT), .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .train_start(train_start),
    .tx_train(tx_train), .tx_en(tx_en), .tx_din(tx_din), .rx_word(rx_word),
    .tx_dout(tx_dout), .tx_tristate(tx_tristate), .bitslip(bitslip),
    .lane_locked(lane_locked), .lane_fail(lane_fail), .link_up(link_up),
    .rx_dout(rx_dout), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Channel model state
  int               off[LANES];
  bit               bad[LANES];
  logic [SER_W-1:0] badval[LANES];
  bit               payload = 1'b0;
  bit               corrupt0 = 1'b0;
  bit               tx_force = 1'b0;
  bit               tx_f_train = 1'b0;
  bit               tx_f_en = 1'b0;

  // Reference model and scoreboards
  int           lock_at[LANES]  = '{default: NEVER};
  int           fail_at[LANES]  = '{default: NEVER};
  int           nlock_at[LANES] = '{default: NEVER};
  int           nfail_at[LANES] = '{default: NEVER};
  int           pend_cyc = -1;
  int           slipq[LANES][$];
  logic [W-1:0] rxq[$];
  logic [W:0]   txq[$];
  bit           mon_en = 1'b0;
  logic         exp_link = 1'b0;
  logic         exp_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s cyc=%0d %s", name, cyc, what);
  endtask

  function automatic logic [SER_W-1:0] rotl(input logic [SER_W-1:0] v, input int n);
    logic [2*SER_W-1:0] d;
    d = {v, v} << n;
    return d[2*SER_W-1 -: SER_W];
  endfunction

  // A word with a different popcount can never be rotated into the pattern.
  function automatic logic [SER_W-1:0] bad_word();
    logic [SER_W-1:0] v;
    for (int k = 0; k < 64; k++) begin
      v = SER_W'($urandom);
      if ($countones(v) != $countones(PAT)) return v;
    end
    return '1;
  endfunction

  // Expected slip pulses and lock/fail cycles for a restart issued in cycle t.
  task automatic start_train(input int t);
    for (int i = 0; i < LANES; i++) begin
      while (slipq[i].size() > 0 && slipq[i][$] > t) void'(slipq[i].pop_back());
      if (bad[i]) begin
        for (int k = 1; k <= int'(SER_W); k++) slipq[i].push_back(t + 2 + (k - 1) * SLIP_P);
        nlock_at[i] = NEVER;
        nfail_at[i] = t + 2 + int'(SER_W) * SLIP_P;
      end else begin
        for (int k = 1; k <= off[i]; k++) slipq[i].push_back(t + 2 + (k - 1) * SLIP_P);
        nlock_at[i] = t + 1 + off[i] * SLIP_P + int'(MATCH_CNT);
        nfail_at[i] = NEVER;
      end
    end
    pend_cyc = t + 1;
  endtask

  task automatic drive(input bit ts);
    logic [W-1:0]     w;
    logic [W-1:0]     rep;
    logic [SER_W-1:0] lw;
    train_start = ts;
    for (int i = 0; i < LANES; i++) begin
      if (payload)     lw = SER_W'($urandom);
      else if (bad[i]) lw = badval[i];
      else             lw = rotl(PAT, off[i]);
      if (i == 0 && corrupt0) lw = ~PAT;
      w[i*SER_W +: SER_W]   = lw;
      rep[i*SER_W +: SER_W] = PAT;
    end
    rx_word = w;
    if (mon_en && exp_link) rxq.push_back(w);
    tx_din = W'({$urandom(), $urandom()});
    if (tx_force) begin
      tx_train = tx_f_train;
      tx_en    = tx_f_en;
    end else begin
      tx_train = 1'($urandom_range(0, 1));
      tx_en    = 1'($urandom_range(0, 1));
    end
    if (mon_en) txq.push_back({~tx_en, tx_train ? rep : tx_din});
    if (ts) start_train(cyc);
  endtask

  task automatic tick(input bit ts);
    @(posedge clk);
    #1;
    drive(ts);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    txq.push_back({1'b1, {W{1'b0}}});
    drive(1'b0);
  endtask

  task automatic end_phase(input string name);
    for (int i = 0; i < LANES; i++)
      check($sformatf("%s_slips_missing_lane%0d", name, i), 64'(slipq[i].size()), 64'd0);
  endtask

  task automatic randomize_lanes();
    for (int i = 0; i < LANES; i++) begin
      bad[i]    = ($urandom_range(0, 4) == 0);
      badval[i] = bad_word();
      off[i]    = int'($urandom_range(0, SER_W - 1));
    end
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < LANES; i++) begin
      bad[i] = 1'b0;
      off[i] = 0;
    end
  endtask

  // Monitor: compares every DUT output against the model on the falling edge.
  always @(negedge clk) begin : mon
    logic [LANES-1:0] el, ef;
    logic [W:0]       te;
    if (mon_en) begin
      if (cyc == pend_cyc) begin
        for (int i = 0; i < LANES; i++) begin
          lock_at[i] = nlock_at[i];
          fail_at[i] = nfail_at[i];
        end
      end
      for (int i = 0; i < LANES; i++) begin
        el[i] = (cyc >= lock_at[i]);
        ef[i] = (cyc >= fail_at[i]);
      end
      check("lane_locked", 64'(lane_locked), 64'(el));
      check("lane_fail", 64'(lane_fail), 64'(ef));
      check("link_up", 64'(link_up), 64'(exp_link));
      check("rx_valid", 64'(rx_valid), 64'(exp_valid));
      for (int i = 0; i < LANES; i++) begin
        if (bitslip[i]) begin
          if (slipq[i].size() == 0)
            fail_now($sformatf("bitslip_unexpected_lane%0d", i), "actual=1 required=0");
          else
            check($sformatf("bitslip_cycle_lane%0d", i), 64'(cyc), 64'(slipq[i].pop_front()));
          off[i] = (off[i] + int'(SER_W) - 1) % int'(SER_W);
        end
      end
      if (rx_valid) begin
        if (rxq.size() == 0) fail_now("rx_dout", "actual=valid required=no data");
        else                 check("rx_dout", 64'(rx_dout), 64'(rxq.pop_front()));
      end
      if (txq.size() == 0) begin
        fail_now("tx_queue", "actual=empty required=entry");
      end else begin
        te = txq.pop_front();
        check("tx_tristate", 64'(tx_tristate), 64'(te[W]));
        check("tx_dout", 64'(tx_dout), 64'(te[W-1:0]));
      end
      exp_valid = exp_link;
      exp_link  = &el;
    end
  end

  initial begin
    reset_n = 1'b0; train_start = 1'b0; tx_train = 1'b0; tx_en = 1'b0;
    tx_din = '0; rx_word = '0;
    for (int i = 0; i < LANES; i++) begin
      off[i] = 0; bad[i] = 1'b0; badval[i] = '0;
    end
    repeat (3) @(posedge clk);

    // Reset release, directed TX training word, then idle with no slips
    tx_force = 1'b1; tx_f_train = 1'b1; tx_f_en = 1'b1;
    release_reset();
    tx_f_train = 1'b0;
    tick(1'b0);
    @(negedge clk);
    check("tx_train_word", 64'(tx_dout), 64'h0F0F0F0F0F);
    check("tx_train_tristate", 64'(tx_tristate), 64'd0);
    tx_force = 1'b0;
    repeat (100) tick(1'b0);
    end_phase("idle");

    // All lanes aligned, payload, corrupted word, restart and relock
    tick(1'b1);
    repeat (25) tick(1'b0);
    payload = 1'b1;
    repeat (30) tick(1'b0);
    payload = 1'b0;
    corrupt0 = 1'b1;
    tick(1'b0);
    corrupt0 = 1'b0;
    repeat (3) tick(1'b0);
    tick(1'b1);
    repeat (25) tick(1'b0);
    end_phase("aligned");

    // Lane 2 rotated by three
    off[2] = 3;
    tick(1'b1);
    repeat (45) tick(1'b0);
    end_phase("rot3");

    // Lane 4 never alignable
    bad[4] = 1'b1; badval[4] = 8'hFF;
    tick(1'b1);
    repeat (70) tick(1'b0);
    end_phase("fail");
    clear_lanes();

    // Random lane offsets and unalignable lanes, one mid-alignment restart
    for (int it = 0; it < 6; it++) begin
      randomize_lanes();
      tick(1'b1);
      if (it == 2) begin
        repeat (4) tick(1'b0);
        randomize_lanes();
        tick(1'b1);
      end
      repeat (66) tick(1'b0);
      end_phase($sformatf("rand%0d", it));
    end
    clear_lanes();

    // Asynchronous reset while the link carries payload
    tick(1'b1);
    repeat (20) tick(1'b0);
    payload = 1'b1;
    repeat (3) tick(1'b0);
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("arst_tx_dout", 64'(tx_dout), 64'd0);
    check("arst_tx_tristate", 64'(tx_tristate), 64'd1);
    check("arst_bitslip", 64'(bitslip), 64'd0);
    check("arst_lane_locked", 64'(lane_locked), 64'd0);
    check("arst_lane_fail", 64'(lane_fail), 64'd0);
    check("arst_link_up", 64'(link_up), 64'd0);
    check("arst_rx_dout", 64'(rx_dout), 64'd0);
    check("arst_rx_valid", 64'(rx_valid), 64'd0);
    payload = 1'b0;
    rxq.delete();
    txq.delete();
    for (int i = 0; i < LANES; i++) begin
      slipq[i].delete();
      lock_at[i] = NEVER; fail_at[i] = NEVER;
      nlock_at[i] = NEVER; nfail_at[i] = NEVER;
    end
    pend_cyc = -1; exp_link = 1'b0; exp_valid = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    repeat (10) tick(1'b0);
    end_phase("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serdes_lane_align.md
# serdes_lane_align

Parametrised LVDS serdes link-alignment block for the F2F link, sitting between the per-lane serializer/deserializer primitives and the link user logic. It drives the TX lanes with a training word or user data, and owns the tristate enable. On the RX side it runs an independent bitslip-alignment state machine per lane, reports per-lane lock and failure, and gates received data until every lane is aligned.

## Interface
Parameters:
- LANES, 5, number of serdes lanes.
- SER_W, 8, deserialization factor (bits per lane word).
- TRAIN_PAT, 8'h0F, training word; all SER_W rotations must be distinct.
- MATCH_CNT, 16, consecutive matching words needed to lock a lane; must be ≥ 2.
- SLIP_WAIT, 4, idle cycles after a bitslip pulse before re-checking; must be ≥ 1.

Ports (one clock `clk`; reset `reset_n` is asynchronous, active-low):
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- train_start  in  1  single-cycle pulse: (re)start alignment of all lanes.
- tx_train  in  1  1 = transmit TRAIN_PAT on every lane.
- tx_en  in  1  1 = drive TX pads.
- tx_din  in  LANES*SER_W  user TX data, lane i at [i*SER_W +: SER_W].
- rx_word  in  LANES*SER_W  parallel words from the deserializers.
- tx_dout  out  LANES*SER_W  words to the serializers.
- tx_tristate  out  1  1 = TX pads high-Z.
- bitslip  out  LANES  one-cycle bitslip pulse per lane.
- lane_locked  out  LANES  per-lane aligned.
- lane_fail  out  LANES  per-lane alignment failed.
- link_up  out  1  all lanes locked.
- rx_dout  out  LANES*SER_W  registered RX data.
- rx_valid  out  1  rx_dout qualified.

## Operation
- Reset values:
  - tx_dout = 0, tx_tristate = 1.
  - bitslip, lane_locked, lane_fail, link_up, rx_dout and rx_valid = 0.
  - All lane FSMs in IDLE with counters at 0.
- TX path:
  - tx_dout <= tx_train ? {LANES{TRAIN_PAT}} : tx_din.
  - tx_tristate <= ~tx_en.
- Per-lane FSM states: IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL.
  - IDLE: wait for train_start.
  - CHECK, match: match_cnt increments. When match_cnt == MATCH_CNT-1 and the word matches, go to LOCKED.
  - CHECK, mismatch: if slip_cnt == SER_W, go to FAIL; otherwise go to SLIP.
  - SLIP: bitslip = 1 for exactly this cycle; slip_cnt++; go to WAIT.
  - WAIT: hold SLIP_WAIT cycles with match_cnt cleared, then go to CHECK.
  - LOCKED and FAIL: absorbing until the next train_start or reset.
- Any state + train_start → CHECK with match_cnt = 0 and slip_cnt = 0. This includes a restart mid-alignment. train_start has priority over every other transition.
- lane_locked[i] = (state == LOCKED); lane_fail[i] = (state == FAIL). Both are registered state decodes.
- link_up <= &lane_locked. It drops the cycle after any lane leaves LOCKED.
- rx_dout <= rx_word every cycle; rx_valid <= link_up.
- Counter widths: match_cnt is $clog2(MATCH_CNT+1) bits; slip_cnt is $clog2(SER_W+1) bits. Neither counter wraps; each saturates at its terminal value.

## Timing
- TX: 1-cycle latency from tx_din, tx_train or tx_en to tx_dout or tx_tristate.
- Alignment, with train_start at cycle T and lane i matching from T+1 onward:
  - lane_locked[i] rises at T+MATCH_CNT+1.
  - link_up rises at T+MATCH_CNT+2.
  - rx_valid rises at T+MATCH_CNT+3.
- Each slip costs 2+SLIP_WAIT cycles before the next comparison: SLIP, then SLIP_WAIT WAIT cycles, then CHECK.
- Worst-case lock occurs after SER_W-1 slips.
- A mismatch after SER_W slips asserts lane_fail on the following cycle; no further bitslip is issued.
- A lane that locks early holds lock while the other lanes continue aligning.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous); no bitslip glitch is allowed.

## Structure
- Package serdes_align_pkg holds:
  - the lane_state_t enum (IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL);
  - the default TRAIN_PAT;
  - MATCH_CNT and SLIP_WAIT defaults.
- Sub-module lane_align_fsm: one lane's FSM and counters.
  - Inputs: clk, reset_n, train_start, its SER_W slice of rx_word.
  - Outputs: bitslip, locked, fail.
  - Instantiated LANES times via generate.
- The top level holds the TX registers, the link_up/rx_dout/rx_valid registers and the generate loop.

## Test plan
- Reset release with no stimulus → tx_tristate=1; all other outputs 0; no bitslip pulse for 100 cycles.
- Pulse train_start; every lane already presenting 8'h0F → single-cycle bitslip never asserted; lane_locked=5'h1F at T+17; link_up at T+18; rx_valid at T+19.
- Lane 2 presents 8'h0F rotated left by 3 and the model applies each slip after SLIP_WAIT → exactly 3 bitslip[2] pulses, each 6 cycles apart; lane 2 locks; the other lanes lock at T+17.
- Lane 4 presents constant 8'hFF → 8 bitslip[4] pulses, then lane_fail[4]=1; link_up stays 0; no 9th pulse.
- Link up, then inject one corrupted word on lane 0 and pulse train_start → lane_locked[0] falls, link_up falls the next cycle, rx_valid falls one cycle later; the link relocks after MATCH_CNT clean words.
- tx_train=1, tx_en=1 → tx_dout=40'h0F0F0F0F0F and tx_tristate=0 one cycle later; tx_train=0 → tx_dout follows tx_din with 1-cycle latency.
